wb_burst_reader: RTL

- Wishbone master that fetches a block of consecutive 32-bit words from a slave on the shared `wishbone` bus.
- Issues an incrementing burst; fetched words go into an internal FIFO, which drains through a valid/ready stream port.
- Sits directly upstream of stream consumers (e.g. JPEG/DVGA input).
- Its `wb_*` ports connect one-to-one to the `wishbone` interface master-modport signals.

---
 rtl/wb_burst_reader_if.sv | 26 ++
 rtl/wb_burst_reader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wb_burst_reader_if.sv
// Wishbone bus bundle between the burst reader (master) and a memory slave.
// Classic pipelined-less handshake: stb/cyc out, ack/err/rty back.
interface wb_burst_reader_if;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic        wb_stb;
    logic        wb_cyc;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_dat_i;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_rty;

    modport master (
        output wb_adr, wb_dat_o, wb_we, wb_sel, wb_stb, wb_cyc, wb_cti, wb_bte,
        input  wb_dat_i, wb_ack, wb_err, wb_rty
    );

    modport slave (
        input  wb_adr, wb_dat_o, wb_we, wb_sel, wb_stb, wb_cyc, wb_cti, wb_bte,
        output wb_dat_i, wb_ack, wb_err, wb_rty
    );
endinterface

// File: rtl/wb_burst_reader.sv
// Generic synchronous first-word-fall-through FIFO with occupancy count.
// Latency: a pushed word is visible on pop_dat the cycle after the push.
// Backpressure: push is dropped when full unless a pop happens the same cycle.
module wb_burst_reader_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop_rdy,
    output logic                       pop_vld,
    output logic [W-1:0]               pop_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign pop_vld = (count != '0);
    assign do_pop  = pop_rdy && pop_vld;
    assign do_push = push_vld && ((count != CW'(DEPTH)) || do_pop);
    // Head is forced to zero while empty so the output is clean out of reset.
    assign pop_dat = pop_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Wishbone incrementing-burst reader feeding a FWFT stream FIFO.
// Latency: first stb the cycle after start; one word per cycle while ack is continuous.
// Backpressure: stb is withheld while the FIFO has no free slot (a same-cycle pop counts).
module wb_burst_reader #(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       src_adr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err_flag,
    wb_burst_reader_if.master wb,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_BREAK, S_DONE} state_t;

    state_t           state;
    logic [31:0]      adr;
    logic [LEN_W-1:0] remaining;
    logic [CW-1:0]    fifo_cnt;
    logic             pop;
    logic             has_space;
    logic             last_beat;
    logic             take_err;
    logic             take_rty;
    logic             take_ack;

    assign pop       = out_valid && out_ready;
    assign has_space = (fifo_cnt != CW'(FIFO_DEPTH)) || pop;
    assign last_beat = (remaining == LEN_W'(1));

    assign wb.wb_stb   = (state == S_BURST) && has_space;
    assign wb.wb_cyc   = (state == S_BURST) || (state == S_BREAK);
    assign wb.wb_sel   = wb.wb_cyc ? 4'hF : 4'h0;
    assign wb.wb_adr   = adr;
    // S_BREAK is the idle beat after a retry; cti returns to classic there.
    assign wb.wb_cti   = (state == S_BURST) ? (last_beat ? 3'b111 : 3'b010) : 3'b000;
    assign wb.wb_bte   = 2'b00;
    assign wb.wb_we    = 1'b0;
    assign wb.wb_dat_o = 32'h0;

    assign take_err = wb.wb_stb && wb.wb_err;
    assign take_rty = wb.wb_stb && !wb.wb_err && wb.wb_rty;
    assign take_ack = wb.wb_stb && !wb.wb_err && !wb.wb_rty && wb.wb_ack;

    wb_burst_reader_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .push_vld (take_ack),
        .push_dat (wb.wb_dat_i),
        .pop_rdy  (out_ready),
        .pop_vld  (out_valid),
        .pop_dat  (out_data),
        .count    (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            adr       <= 32'h0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err_flag <= 1'b0;
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            adr       <= src_adr & ~32'h3;
                            remaining <= len;
                            busy      <= 1'b1;
                            state     <= S_BURST;
                        end
                    end
                end
                S_BURST: begin
                    if (take_err) begin
                        err_flag <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_DONE;
                    end else if (take_rty) begin
                        state <= S_BREAK;
                    end else if (take_ack) begin
                        adr       <= adr + 32'd4;
                        remaining <= remaining - LEN_W'(1);
                        if (last_beat) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end
                    end
                end
                S_BREAK: state <= S_BURST;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
